// File: rtl/linear_sched_pkg.sv
// rtl/linear_sched_pkg.sv - shared constants and state type for the linear layer scheduler
package linear_sched_pkg;

    localparam int DEF_DATA_W    = 32;
    localparam int DEF_ADDR_W    = 5;
    localparam int DEF_FRAME_LEN = 20;
    localparam int DEF_OUT_LEN   = 20;
    localparam int DEF_TIMEOUT   = 255;

    localparam logic [1:0] LIN_MODE_CMVN = 2'b00;
    localparam logic [1:0] LIN_MODE_RELU = 2'b01;

    // Requester identity as stored in the grant / last-grant registers
    localparam logic PORT_CMVN = 1'b0;
    localparam logic PORT_RELU = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        STREAM,
        DRAIN,
        DONE
    } sched_state_t;

endpackage

// File: rtl/linear_sched_if.sv
// rtl/linear_sched_if.sv - requester, buffer and linear-datapath signals of the scheduler
interface linear_sched_if
    import linear_sched_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) ();

    logic              cmvn_req;
    logic              cmvn_ack;
    logic [ADDR_W-1:0] cmvn_rd_addr;
    logic [DATA_W-1:0] cmvn_rd_data;
    logic              relu_req;
    logic              relu_ack;
    logic [ADDR_W-1:0] relu_rd_addr;
    logic [DATA_W-1:0] relu_rd_data;
    logic              linear_en;
    logic [1:0]        linear_mode;
    logic              lin_in_valid;
    logic [ADDR_W-1:0] lin_in_addr;
    logic [DATA_W-1:0] lin_in_data;
    logic              lin_out_valid;
    logic              busy;
    logic              frame_done;
    logic              err;
    logic              err_clr;

    // Scheduler side
    modport master (
        input  cmvn_req, cmvn_rd_data, relu_req, relu_rd_data, lin_out_valid, err_clr,
        output cmvn_ack, cmvn_rd_addr, relu_ack, relu_rd_addr, linear_en, linear_mode,
               lin_in_valid, lin_in_addr, lin_in_data, busy, frame_done, err
    );

    // Producers, buffers and linear datapath side
    modport slave (
        output cmvn_req, cmvn_rd_data, relu_req, relu_rd_data, lin_out_valid, err_clr,
        input  cmvn_ack, cmvn_rd_addr, relu_ack, relu_rd_addr, linear_en, linear_mode,
               lin_in_valid, lin_in_addr, lin_in_data, busy, frame_done, err
    );

endinterface

// File: rtl/linear_sched_rr_arb2.sv
// rtl/linear_sched_rr_arb2.sv - two-way round-robin arbiter (bit0 CMVN, bit1 ReLU)
module linear_sched_rr_arb2
    import linear_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic last;

    // A tie goes to whichever side was not served last
    assign gnt[0] = req[0] & (~req[1] | (last == PORT_RELU));
    assign gnt[1] = req[1] & (~req[0] | (last == PORT_CMVN));

    // Remember the side taken when the grant is accepted; starts as ReLU so CMVN wins the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last <= PORT_RELU;
        else if (advance && (gnt != 2'b00))
            last <= gnt[1];
    end

endmodule

// File: rtl/linear_sched.sv
// rtl/linear_sched.sv - grants the shared linear layer to CMVN or ReLU and sequences one frame
module linear_sched
    import linear_sched_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int FRAME_LEN = DEF_FRAME_LEN,
    parameter int OUT_LEN   = DEF_OUT_LEN,
    parameter int TIMEOUT   = DEF_TIMEOUT
) (
    input logic           clk,
    input logic           rst_n,
    linear_sched_if.master bus
);

    localparam int CNT_W  = $clog2(OUT_LEN + 1);
    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] LAST_K   = ADDR_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0]  OUT_FULL = CNT_W'(OUT_LEN);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT);
    localparam logic [IDLE_W-1:0] IDLE_LIM = IDLE_W'(TIMEOUT - 1);

    sched_state_t      state, state_nxt;
    logic [1:0]        gnt;
    logic              grab;
    logic              grant_relu;
    logic [1:0]        mode_q;
    logic [ADDR_W-1:0] k;
    logic [CNT_W-1:0]  out_cnt;
    logic [IDLE_W-1:0] idle_cnt;
    logic              in_valid_q;
    logic [ADDR_W-1:0] in_addr_q;
    logic [DATA_W-1:0] fwd_data;
    logic              err_q;
    logic              addr_phase;
    logic              out_window;
    logic              timeout_hit;

    assign grab        = (state == IDLE) && (gnt != 2'b00);
    assign addr_phase  = (state == START) || (state == STREAM);
    assign out_window  = addr_phase || (state == DRAIN);
    assign timeout_hit = (state == DRAIN) && !bus.lin_out_valid &&
                         (out_cnt != OUT_FULL) && (idle_cnt == IDLE_LIM);

    linear_sched_rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     ({bus.relu_req, bus.cmvn_req}),
        .advance (grab),
        .gnt     (gnt)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state: grant, one start cycle, FRAME_LEN addresses, wait for results, ack
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grab) state_nxt = START;
            START:   state_nxt = STREAM;
            STREAM:  if (k == LAST_K) state_nxt = DRAIN;
            DRAIN:   if ((out_cnt == OUT_FULL) || timeout_hit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Grant side and linear mode are captured at the grant and held until the next one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_relu <= PORT_CMVN;
            mode_q     <= LIN_MODE_CMVN;
        end else if (grab) begin
            grant_relu <= gnt[1];
            mode_q     <= gnt[1] ? LIN_MODE_RELU : LIN_MODE_CMVN;
        end
    end

    // Element address counter: 0 in START, advances through STREAM, parked at 0 elsewhere
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            k <= '0;
        else if (state == STREAM)
            k <= k + 1'b1;
        else
            k <= '0;
    end

    // Result counter: accepts outputs from START onward so a pipelined linear is fine; saturates
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            out_cnt <= '0;
        else if (state == IDLE)
            out_cnt <= '0;
        else if (out_window && bus.lin_out_valid && (out_cnt != OUT_FULL))
            out_cnt <= out_cnt + 1'b1;
    end

    // Cycles since the last result; only meaningful while streaming or draining
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            idle_cnt <= '0;
        else if (bus.lin_out_valid || !((state == STREAM) || (state == DRAIN)))
            idle_cnt <= '0;
        else if (idle_cnt != IDLE_MAX)
            idle_cnt <= idle_cnt + 1'b1;
    end

    // Forward register: the element addressed in cycle k reaches linear in cycle k+1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_valid_q <= 1'b0;
            in_addr_q  <= '0;
        end else begin
            in_valid_q <= (state == STREAM);
            in_addr_q  <= (state == STREAM) ? k : '0;
        end
    end

    // Sticky timeout flag; a clear in the same cycle as a timeout wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_q <= 1'b0;
        else if (bus.err_clr)
            err_q <= 1'b0;
        else if (timeout_hit)
            err_q <= 1'b1;
    end

    assign fwd_data = grant_relu ? bus.relu_rd_data : bus.cmvn_rd_data;

    assign bus.busy         = (state != IDLE);
    assign bus.linear_en    = (state == START);
    assign bus.frame_done   = (state == DONE);
    assign bus.cmvn_ack     = (state == DONE) && (grant_relu == PORT_CMVN);
    assign bus.relu_ack     = (state == DONE) && (grant_relu == PORT_RELU);
    assign bus.cmvn_rd_addr = (addr_phase && (grant_relu == PORT_CMVN)) ? k : '0;
    assign bus.relu_rd_addr = (addr_phase && (grant_relu == PORT_RELU)) ? k : '0;
    assign bus.linear_mode  = mode_q;
    assign bus.lin_in_valid = in_valid_q;
    assign bus.lin_in_addr  = in_addr_q;
    assign bus.lin_in_data  = in_valid_q ? fwd_data : '0;
    assign bus.err          = err_q;

endmodule
